mdu_seq: RTL

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: sequential multiply/divide unit (shift-add multiply, restoring divide).
// Ports: clk, rst (async, active-high); in_valid/in_ready request handshake with
// src1, src2, op; out_valid/out_ready result handshake with res and flags
// ([0] zero, [1] sign, [2] divide-by-zero, [3] signed overflow).
// Optional feature: define MDU_SEQ_FAST_MUL_EN for a single-cycle multiplier.
module mdu_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] src1,
    input  logic [N-1:0] src2,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res,
    output logic [3:0]   flags
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*N-1:0] p_q, p_d;
    logic [N-1:0] b_q, b_d, res_q, res_d, m1, m2;
    logic [2:0] op_q, op_d;
    logic [3:0] flags_q, flags_d;
    logic sneg_q, sneg_d, s1neg_q, s1neg_d, s1s, s2s, n1, n2, dbz, ovf;
    logic [N:0] sh, df, sm;
    // p holds {accumulator, multiplier} for multiply, {remainder, quotient} for divide;
    // results are magnitudes until the sign is applied here.
    function automatic logic [N-1:0] finish_res(input logic [2:0] o, input logic [2*N-1:0] p,
                                                input logic sn, input logic s1n);
        logic [2*N-1:0] prod;
        logic [N-1:0] q, r;
        prod = sn ? -p : p;
        q = sn ? -p[N-1:0] : p[N-1:0];
        r = s1n ? -p[2*N-1:N] : p[2*N-1:N];
        return !o[2] ? (o[1:0] == 2'b00 ? prod[N-1:0] : prod[2*N-1:N]) : (o[1] ? r : q);
    endfunction
    assign s1s = op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110;
    assign s2s = op == 3'b001 || op == 3'b100 || op == 3'b110;
    assign n1 = s1s && src1[N-1];
    assign n2 = s2s && src2[N-1];
    assign m1 = n1 ? -src1 : src1;
    assign m2 = n2 ? -src2 : src2;
    assign dbz = op[2] && src2 == '0;
    assign ovf = op[2] && !op[0] && src1 == {1'b1, {N-1{1'b0}}} && src2 == '1;
    // Remainder < divisor, so the shifted partial remainder fits in N+1 bits.
    assign sh = {p_q[2*N-1:N], p_q[N-1]};
    assign df = sh - {1'b0, b_q};
    assign sm = {1'b0, p_q[2*N-1:N]} + (p_q[0] ? {1'b0, b_q} : '0);
`ifdef MDU_SEQ_FAST_MUL_EN
    logic [2*N-1:0] fast_p;
    assign fast_p = {{N{1'b0}}, m1} * {{N{1'b0}}, m2};
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        b_d     = b_q;
        op_d    = op_q;
        sneg_d  = sneg_q;
        s1neg_d = s1neg_q;
        res_d   = res_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d    = op;
                sneg_d  = n1 ^ n2;
                s1neg_d = n1;
                cnt_d   = CW'(N);
                state_d = BUSY;
                p_d     = {{N{1'b0}}, op[2] ? m1 : m2};
                b_d     = op[2] ? m2 : m1;
                if (dbz || ovf) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    res_d   = dbz ? (op[1] ? src1 : '1) : (op[1] ? '0 : src1);
                    flags_d = {ovf, dbz, res_d[N-1], res_d == '0};
                end
`ifdef MDU_SEQ_FAST_MUL_EN
                else if (!op[2]) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    res_d   = finish_res(op, fast_p, n1 ^ n2, n1);
                    flags_d = {2'b00, res_d[N-1], res_d == '0};
                end
`endif
            end
            BUSY: begin
                p_d   = op_q[2] ? (df[N] ? {sh[N-1:0], p_q[N-2:0], 1'b0}
                                         : {df[N-1:0], p_q[N-2:0], 1'b1})
                                : {sm, p_q[N-1:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    res_d   = finish_res(op_q, p_d, sneg_q, s1neg_q);
                    flags_d = {2'b00, res_d[N-1], res_d == '0};
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            sneg_q  <= 1'b0;
            s1neg_q <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            b_q     <= b_d;
            op_q    <= op_d;
            sneg_q  <= sneg_d;
            s1neg_q <= s1neg_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign res       = res_q;
    assign flags     = flags_q;
endmodule
